// File: rtl/lstm_seq_ctrl.sv
// lstm_seq_ctrl
//   Sequencer for one LSTM layer across i_seq_len timesteps. Drives the layer
//   h_prev select (zero at t=0, recurrent afterwards), accepts x with a
//   valid/ready handshake, waits a fixed compute latency, pulses the h/c
//   latch, presents h downstream with valid/ready and optionally pulses a
//   weight/bias write once the whole sequence has been processed.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   i_start         start a sequence (sampled in IDLE only)
//   i_seq_len       timesteps in the sequence, latched on start
//   i_upd_en        latched on start; 1 = pulse o_wr after the last step
//   i_abort         synchronous abort, back to IDLE with t=0
//   i_x_valid       upstream x available
//   o_x_ready       controller accepts x
//   o_x_ld          x register enable (i_x_valid & o_x_ready)
//   o_sel           layer h_prev mux: 0 = zero, 1 = recurrent h
//   o_load_h        1-cycle pulse: layer latches h/c state
//   o_wr            1-cycle pulse: layer loads weights/biases
//   o_h_valid       layer h valid for downstream
//   i_h_ready       downstream accepts h
//   o_t             current timestep index
//   o_busy          high in every state except IDLE
//   o_done          1-cycle pulse at sequence completion
module lstm_seq_ctrl #(
  parameter int unsigned LEN_W       = 8,
  parameter int unsigned COMPUTE_CYC = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [LEN_W-1:0] i_seq_len,
  input  logic             i_upd_en,
  input  logic             i_abort,
  input  logic             i_x_valid,
  output logic             o_x_ready,
  output logic             o_x_ld,
  output logic             o_sel,
  output logic             o_load_h,
  output logic             o_wr,
  output logic             o_h_valid,
  input  logic             i_h_ready,
  output logic [LEN_W-1:0] o_t,
  output logic             o_busy,
  output logic             o_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_X,
    S_COMPUTE,
    S_LATCH,
    S_OUT,
    S_UPDATE,
    S_DONE
  } state_t;

  state_t           state, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] t_q, t_d;
  logic             upd_q, upd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state;
    len_d   = len_q;
    t_d     = t_q;
    upd_d   = upd_q;
    cnt_d   = cnt_q;

    unique case (state)
      S_IDLE: begin
        if (i_start) begin
          t_d = '0;
          if (i_seq_len != '0) begin
            len_d   = i_seq_len;
            upd_d   = i_upd_en;
            state_d = S_WAIT_X;
          end else begin
            // Empty sequence: report completion without touching the layer.
            state_d = S_DONE;
          end
        end
      end
      S_WAIT_X: begin
        if (i_x_valid) begin
          cnt_d   = CNT_W'(COMPUTE_CYC - 1);
          state_d = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        if (cnt_q == '0) state_d = S_LATCH;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_LATCH: state_d = S_OUT;
      S_OUT: begin
        if (i_h_ready) begin
          if (t_q == len_q - LEN_W'(1)) begin
            state_d = upd_q ? S_UPDATE : S_DONE;
          end else begin
            t_d     = t_q + LEN_W'(1);
            state_d = S_WAIT_X;
          end
        end
      end
      S_UPDATE: state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (i_abort) begin
      state_d = S_IDLE;
      t_d     = '0;
    end
  end

  // Outputs are decoded from the next state so they are registered yet
  // line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      len_q     <= '0;
      t_q       <= '0;
      upd_q     <= 1'b0;
      cnt_q     <= '0;
      o_x_ready <= 1'b0;
      o_sel     <= 1'b0;
      o_load_h  <= 1'b0;
      o_wr      <= 1'b0;
      o_h_valid <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      state     <= state_d;
      len_q     <= len_d;
      t_q       <= t_d;
      upd_q     <= upd_d;
      cnt_q     <= cnt_d;
      o_x_ready <= (state_d == S_WAIT_X);
      o_sel     <= (state_d != S_IDLE) && (t_d != '0);
      o_load_h  <= (state_d == S_LATCH);
      o_wr      <= (state_d == S_UPDATE);
      o_h_valid <= (state_d == S_OUT);
      o_busy    <= (state_d != S_IDLE);
      o_done    <= (state_d == S_DONE);
    end
  end

  assign o_t    = t_q;
  assign o_x_ld = i_x_valid & o_x_ready;

endmodule
